pcileech_demux: RTL and testbench
=================================

// Module: pcileech_demux
// PURPOSE
//  Inverse of the 4-port 256-bit word mux. Takes 256-bit words (1 status word + 7 data words).
//  Routes each 32-bit data word, with its 2-bit ctx, to one of 4 output ports.
//  Sits between the FT601 RX FIFO and the per-function command/config/loopback FIFOs.
//  Emits one slot per cycle; filler slots are dropped; malformed words are discarded.
// PARAMETERS
//  MARKER  4'hE  required value of status nibble din[231:228]; any other value -> word dropped
// PORTS
//  clk           in   1    single clock
//  rst           in   1    asynchronous, active-high reset
//  din           in   256  packed word
//  din_valid     in   1    din holds a word
//  din_ready     out  1    word accepted when din_valid & din_ready at posedge clk
//  pN_dout       out  32   N=0..3; data word for port N
//  pN_ctx        out  2    N=0..3; ctx for the word on pN_dout
//  pN_wr_en      out  1    N=0..3; write strobe for port N
//  pN_full       in   1    N=0..3; almost-full from port N's FIFO, >=2 entries of slack
//  err_marker    out  1    1-cycle pulse: word dropped on bad marker
// BEHAVIOUR
//  - Slot map, k=0 first-written. Data slot k = din[223-32k -: 32].
//    Status nibble per slot: k0 [251:248], k1 [255:252], k2 [243:240], k3 [247:244],
//    k4 [235:232], k5 [239:236], k6 [227:224].
//  - Nibble decode: [1:0] = port, [3:2] = ctx. Nibble 4'hF = filler, always skipped.
//    Port3/ctx3 is reserved.
//  - FSM states:
//    IDLE: din_ready=1. On accept, latch din into word_q and go to CHECK.
//    CHECK: marker != MARKER -> pulse err_marker, go to IDLE (0 writes). Else slot=0, go to EMIT.
//    EMIT: evaluate slot (3-bit counter).
//      Filler -> advance.
//      Target pN_full=1 -> hold slot; in-order, head-of-line stall.
//      Otherwise -> register a write and advance.
//      After slot 6 advances -> IDLE.
//  - Outputs are registered: a write decided in cycle t is visible on pN_* in cycle t+1.
//    pN_wr_en is high for exactly one cycle per word. At most one pN_wr_en high per cycle.
//  - pN_dout/pN_ctx hold their last value while pN_wr_en=0.
//  - Throughput: 1 word per 9 cycles (accept, check, 7 slots). No overlap, fixed order.
//  - pN_full is sampled in the evaluating cycle; the 2-entry slack covers the registered write.
//  - din_valid is ignored outside IDLE. din need not be held after accept.
//  - Reset (async, any time) drives state=IDLE, slot=0, all pN_wr_en=0, pN_dout=0, pN_ctx=0,
//    err_marker=0, din_ready=0 during reset, and word_q=0.
//    A partially emitted word is lost; no further writes from it.
//  - Simultaneous full deassert and reset: reset wins.
//    Full toggling mid-word: resume at the held slot, no duplicate or lost slot.
// CONFIGURATION
//  - DEMUX_STATS_EN defined adds:
//    - stat_words out [15:0]: words accepted with a good marker.
//    - stat_drops out [15:0]: bad-marker words.
//    - stat_fill out [15:0]: filler slots.
//    All three are free-running, wrap at 16'hFFFF->0, and reset to 0.
//  - DEMUX_STATS_EN undefined: these ports and counters are absent; the rest is identical.
// STRUCTURE
//  - Package pcileech_demux_pkg:
//    - typedef slot_nib_t (struct: ctx[1:0], port[1:0]).
//    - localparam NIB_FILLER=4'hF, MARKER_DEFAULT=4'hE.
//    - function nib_of_slot(word, k) encoding the slot map above.
//  - One sub-module, pcileech_demux_port: the registered output stage for one port (dout/ctx/wr_en).
//    Instantiated 4x.
// TESTING
//  1. One word, slots 0..6 = data 32'h1000_0000+k; nibbles 0x0,0x1,0x2,0x3,0x4,0x5,0x6; marker E.
//     -> p0..p3 receive in order with ctx 0,0,0,0,1,1,1, ports 0,1,2,3,0,1,2.
//  2. All 7 nibbles 0xF, marker E.
//     -> no pN_wr_en, din_ready back high 9 cycles after accept.
//  3. Marker 0xD, valid payload.
//     -> err_marker pulses once, zero writes, next good word decodes normally.
//  4. All slots to port2; p2_full=1 for 20 cycles starting at slot 3.
//     -> slots 0-2 written, stall, then slots 3-6 written exactly once each in order.
//  5. Assert rst asynchronously after the 3rd write of a 7-write word.
//     -> outputs 0 immediately, no further writes; the next word decodes from slot 0.
//  6. Back-to-back 100 random words, scoreboard vs a software model of the mux packing.
//     -> exact per-port sequence match. With DEMUX_STATS_EN, counters match the model.

Source files
------------

// File: rtl/pcileech_demux_pkg.sv
// Shared types and slot-map helpers for the 256-bit word demultiplexer.
// The status word carries one routing nibble per data slot plus a marker nibble.
package pcileech_demux_pkg;

    typedef struct packed {
        logic [1:0] ctx;
        logic [1:0] port;
    } slot_nib_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EMIT
    } state_t;

    localparam logic [3:0] NIB_FILLER     = 4'hF;
    localparam logic [3:0] MARKER_DEFAULT = 4'hE;
    localparam logic [2:0] LAST_SLOT      = 3'd6;

    // Status nibbles are interleaved in pairs, not laid out in slot order.
    function automatic slot_nib_t nib_of_slot(input logic [255:0] word, input logic [2:0] k);
        logic [3:0] nib;
        case (k)
            3'd0:    nib = word[251:248];
            3'd1:    nib = word[255:252];
            3'd2:    nib = word[243:240];
            3'd3:    nib = word[247:244];
            3'd4:    nib = word[235:232];
            3'd5:    nib = word[239:236];
            3'd6:    nib = word[227:224];
            default: nib = NIB_FILLER;
        endcase
        return slot_nib_t'(nib);
    endfunction

    function automatic logic [31:0] data_of_slot(input logic [255:0] word, input logic [2:0] k);
        return word[223 - 32 * int'(k) -: 32];
    endfunction

endpackage

// File: rtl/pcileech_demux_port.sv
// Registered output stage for one destination port: write strobe plus held data/ctx.
module pcileech_demux_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] data,
    input  logic [1:0]  ctx,
    output logic [31:0] dout,
    output logic [1:0]  dout_ctx,
    output logic        wr_en
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en    <= 1'b0;
            dout     <= '0;
            dout_ctx <= '0;
        end else begin
            wr_en <= wr;
            if (wr) begin
                dout     <= data;
                dout_ctx <= ctx;
            end
        end
    end

endmodule

// File: rtl/pcileech_demux.sv
// Splits marked 256-bit words into per-port 32-bit writes, one slot per cycle, in slot order.
// Optional statistics counters are built when DEMUX_STATS_EN is defined.
module pcileech_demux
    import pcileech_demux_pkg::*;
#(
    parameter logic [3:0] MARKER = MARKER_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [31:0]  p0_dout,
    output logic [1:0]   p0_ctx,
    output logic         p0_wr_en,
    input  logic         p0_full,
    output logic [31:0]  p1_dout,
    output logic [1:0]   p1_ctx,
    output logic         p1_wr_en,
    input  logic         p1_full,
    output logic [31:0]  p2_dout,
    output logic [1:0]   p2_ctx,
    output logic         p2_wr_en,
    input  logic         p2_full,
    output logic [31:0]  p3_dout,
    output logic [1:0]   p3_ctx,
    output logic         p3_wr_en,
    input  logic         p3_full,
    output logic         err_marker
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]  stat_words,
    output logic [15:0]  stat_drops,
    output logic [15:0]  stat_fill
`endif
);

    state_t       state_q, state_d;
    logic [2:0]   slot_q, slot_d;
    logic [255:0] word_q;
    logic         load;
    logic         err_d;
    logic         marker_ok;
    logic         is_filler;
    logic         advance;
    logic [3:0]   full;
    logic [3:0]   wr_sel;
    slot_nib_t    nib;
    logic [31:0]  slot_data;

    assign full      = {p3_full, p2_full, p1_full, p0_full};
    assign din_ready = (state_q == ST_IDLE) && !rst;
    assign marker_ok = (word_q[231:228] == MARKER);
    assign nib       = nib_of_slot(word_q, slot_q);
    assign is_filler = (nib == slot_nib_t'(NIB_FILLER));
    assign slot_data = data_of_slot(word_q, slot_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        load    = 1'b0;
        err_d   = 1'b0;
        advance = 1'b0;
        wr_sel  = '0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    load    = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                slot_d = 3'd0;
                if (marker_ok) begin
                    state_d = ST_EMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                // A full target holds the slot: later slots never overtake it.
                if (is_filler) begin
                    advance = 1'b1;
                end else if (!full[nib.port]) begin
                    wr_sel[nib.port] = 1'b1;
                    advance          = 1'b1;
                end
                if (advance) begin
                    if (slot_q == LAST_SLOT) begin
                        slot_d  = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: word_q is a plain register, not a memory, so it takes the async reset with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= 3'd0;
            word_q     <= '0;
            err_marker <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            err_marker <= err_d;
            if (load) begin
                word_q <= din;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words <= '0;
            stat_drops <= '0;
            stat_fill  <= '0;
        end else begin
            if (state_q == ST_CHECK && marker_ok) begin
                stat_words <= stat_words + 16'd1;
            end
            if (state_q == ST_CHECK && !marker_ok) begin
                stat_drops <= stat_drops + 16'd1;
            end
            if (state_q == ST_EMIT && is_filler) begin
                stat_fill <= stat_fill + 16'd1;
            end
        end
    end
`endif

    pcileech_demux_port u_port0 (
        .clk(clk), .rst(rst), .wr(wr_sel[0]), .data(slot_data), .ctx(nib.ctx),
        .dout(p0_dout), .dout_ctx(p0_ctx), .wr_en(p0_wr_en)
    );
    pcileech_demux_port u_port1 (
        .clk(clk), .rst(rst), .wr(wr_sel[1]), .data(slot_data), .ctx(nib.ctx),
        .dout(p1_dout), .dout_ctx(p1_ctx), .wr_en(p1_wr_en)
    );
    pcileech_demux_port u_port2 (
        .clk(clk), .rst(rst), .wr(wr_sel[2]), .data(slot_data), .ctx(nib.ctx),
        .dout(p2_dout), .dout_ctx(p2_ctx), .wr_en(p2_wr_en)
    );
    pcileech_demux_port u_port3 (
        .clk(clk), .rst(rst), .wr(wr_sel[3]), .data(slot_data), .ctx(nib.ctx),
        .dout(p3_dout), .dout_ctx(p3_ctx), .wr_en(p3_wr_en)
    );

endmodule

// File: tb/tb_pcileech_demux.sv
// Directed and randomized bench for pcileech_demux; writes are logged as {port, ctx, data}.
module tb_pcileech_demux;

    localparam int NIB_LO [7] = '{248, 252, 240, 244, 232, 236, 224};

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  p0_dout, p1_dout, p2_dout, p3_dout;
    logic [1:0]   p0_ctx, p1_ctx, p2_ctx, p3_ctx;
    logic         p0_wr_en, p1_wr_en, p2_wr_en, p3_wr_en;
    logic [3:0]   full;
    logic         err_marker;
`ifdef DEMUX_STATS_EN
    logic [15:0]  stat_words, stat_drops, stat_fill;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int err_samples  = 0;
    int multi_wr     = 0;
    int exp_words    = 0;
    int exp_drops    = 0;
    int exp_fill     = 0;
    logic         rand_full = 1'b0;
    logic [35:0]  got_q [$];

    pcileech_demux dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .p0_dout(p0_dout), .p0_ctx(p0_ctx), .p0_wr_en(p0_wr_en), .p0_full(full[0]),
        .p1_dout(p1_dout), .p1_ctx(p1_ctx), .p1_wr_en(p1_wr_en), .p1_full(full[1]),
        .p2_dout(p2_dout), .p2_ctx(p2_ctx), .p2_wr_en(p2_wr_en), .p2_full(full[2]),
        .p3_dout(p3_dout), .p3_ctx(p3_ctx), .p3_wr_en(p3_wr_en), .p3_full(full[3]),
        .err_marker(err_marker)
`ifdef DEMUX_STATS_EN
        , .stat_words(stat_words), .stat_drops(stat_drops), .stat_fill(stat_fill)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : monitor
        int n;
        #1;
        n = 0;
        if (p0_wr_en) begin got_q.push_back({2'd0, p0_ctx, p0_dout}); n++; end
        if (p1_wr_en) begin got_q.push_back({2'd1, p1_ctx, p1_dout}); n++; end
        if (p2_wr_en) begin got_q.push_back({2'd2, p2_ctx, p2_dout}); n++; end
        if (p3_wr_en) begin got_q.push_back({2'd3, p3_ctx, p3_dout}); n++; end
        if (n > 1) multi_wr++;
        if (err_marker) err_samples++;
    end

    function automatic logic [255:0] mk_word(input logic [6:0][3:0] nibs,
                                             input logic [6:0][31:0] data,
                                             input logic [3:0] marker);
        logic [255:0] w;
        w = '0;
        w[231:228] = marker;
        for (int k = 0; k < 7; k++) begin
            w[NIB_LO[k] +: 4]    = nibs[k];
            w[192 - 32 * k +: 32] = data[k];
        end
        return w;
    endfunction

    function automatic logic [35:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 'x;
    endfunction

    task automatic randomize_full();
        if (rand_full) full = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    endtask

    task automatic send(input logic [255:0] w);
        int n;
        int fills;
        n = 0;
        din = w;
        din_valid = 1'b1;
        while (!din_ready && n < 300) begin
            @(negedge clk);
            randomize_full();
            n++;
        end
        if (n >= 300) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: din_ready=%0b after %0d cycles, required 1", din_ready, n);
        end
        fills = 0;
        for (int k = 0; k < 7; k++) if (((w >> NIB_LO[k]) & 256'hF) == 256'hF) fills++;
        if (w[231:228] == 4'hE) begin exp_words++; exp_fill += fills; end
        else exp_drops++;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        din = ~w;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!din_ready && n < 400) begin
            @(negedge clk);
            randomize_full();
            n++;
        end
        tests_run++;
        if (!din_ready) begin
            tests_failed++;
            $display("FAIL idle_timeout: din_ready=%0b after %0d cycles, required 1", din_ready, n);
        end
    endtask

    task automatic check_seq(input string name, input int base, input logic [6:0][35:0] exp);
        tests_run++;
        if (got_q.size() - base !== 7) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d writes, required 7", name, got_q.size() - base);
        end
        for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (got_at(base + k) !== exp[k]) begin
                tests_failed++;
                $display("FAIL %s_slot%0d: got %h, required %h", name, k, got_at(base + k), exp[k]);
            end
        end
    endtask

    function automatic logic [6:0][35:0] seq_0to6(input logic [31:0] data_base);
        int exp_port [7] = '{0, 1, 2, 3, 0, 1, 2};
        int exp_ctx  [7] = '{0, 0, 0, 0, 1, 1, 1};
        logic [6:0][35:0] e;
        for (int k = 0; k < 7; k++)
            e[k] = {2'(exp_port[k]), 2'(exp_ctx[k]), data_base + 32'(k)};
        return e;
    endfunction

    function automatic logic [255:0] word_0to6(input logic [31:0] data_base, input logic [3:0] marker);
        logic [6:0][3:0]  nibs;
        logic [6:0][31:0] data;
        for (int k = 0; k < 7; k++) begin
            nibs[k] = 4'(k);
            data[k] = data_base + 32'(k);
        end
        return mk_word(nibs, data, marker);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        full = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_din_ready: got %b, required 0", din_ready);
        end
        tests_run++;
        if ({p0_wr_en, p1_wr_en, p2_wr_en, p3_wr_en, err_marker, p0_dout, p1_dout, p2_dout,
             p3_dout, p0_ctx, p1_ctx, p2_ctx, p3_ctx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h %h %h %h, required all 0",
                     p0_dout, p1_dout, p2_dout, p3_dout);
        end
`ifdef DEMUX_STATS_EN
        tests_run++;
        if ({stat_words, stat_drops, stat_fill} !== '0) begin
            tests_failed++;
            $display("FAIL reset_stats: got %h %h %h, required 0", stat_words, stat_drops, stat_fill);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: got %b, required 1", din_ready);
        end
    endtask

    task automatic test_basic_routing();
        int base;
        base = got_q.size();
        send(word_0to6(32'h1000_0000, 4'hE));
        @(negedge clk);
        tests_run++;
        if (got_q.size() - base !== 0) begin
            tests_failed++;
            $display("FAIL latency_early: got %0d writes, required 0", got_q.size() - base);
        end
        @(negedge clk);
        tests_run++;
        if (got_q.size() - base !== 1) begin
            tests_failed++;
            $display("FAIL latency_first: got %0d writes, required 1", got_q.size() - base);
        end
        wait_idle();
        check_seq("basic", base, seq_0to6(32'h1000_0000));
    endtask

    task automatic test_all_filler();
        int base;
        int n;
        logic [6:0][3:0]  nibs;
        logic [6:0][31:0] data;
        for (int k = 0; k < 7; k++) begin
            nibs[k] = 4'hF;
            data[k] = 32'hDEAD_0000 + 32'(k);
        end
        base = got_q.size();
        send(mk_word(nibs, data, 4'hE));
        n = 0;
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL filler_busy: ready low for %0d edges after accept, required 8", n);
        end
        tests_run++;
        if (got_q.size() - base !== 0) begin
            tests_failed++;
            $display("FAIL filler_writes: got %0d writes, required 0", got_q.size() - base);
        end
    endtask

    task automatic test_bad_marker();
        int base;
        int err_base;
        base = got_q.size();
        err_base = err_samples;
        send(word_0to6(32'h5000_0000, 4'hD));
        wait_idle();
        repeat (2) @(negedge clk);
        tests_run++;
        if (err_samples - err_base !== 1) begin
            tests_failed++;
            $display("FAIL err_marker_pulse: high %0d cycles, required 1", err_samples - err_base);
        end
        tests_run++;
        if (got_q.size() - base !== 0) begin
            tests_failed++;
            $display("FAIL bad_marker_writes: got %0d writes, required 0", got_q.size() - base);
        end
        base = got_q.size();
        send(word_0to6(32'h6000_0000, 4'hE));
        wait_idle();
        check_seq("after_bad", base, seq_0to6(32'h6000_0000));
    endtask

    task automatic test_full_stall();
        int base;
        int n;
        int exp_ctx [7] = '{0, 1, 2, 3, 0, 1, 2};
        logic [6:0][3:0]  nibs;
        logic [6:0][31:0] data;
        logic [6:0][35:0] exp;
        for (int k = 0; k < 7; k++) begin
            nibs[k] = {2'(exp_ctx[k]), 2'd2};
            data[k] = 32'h2000_0000 + 32'(k);
            exp[k]  = {2'd2, 2'(exp_ctx[k]), data[k]};
        end
        base = got_q.size();
        send(mk_word(nibs, data, 4'hE));
        n = 0;
        while (got_q.size() - base < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        full[2] = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (got_q.size() - base !== 3) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d writes during full, required 3", got_q.size() - base);
        end
        full[2] = 1'b0;
        wait_idle();
        check_seq("stall", base, exp);
    endtask

    task automatic test_async_reset();
        int base;
        int n;
        base = got_q.size();
        send(word_0to6(32'h3000_0000, 4'hE));
        n = 0;
        while (got_q.size() - base < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        exp_words = 0;
        exp_drops = 0;
        exp_fill  = 0;
        #1;
        tests_run++;
        if ({p0_wr_en, p1_wr_en, p2_wr_en, p3_wr_en, err_marker, din_ready, p0_dout, p1_dout,
             p2_dout, p3_dout, p0_ctx, p1_ctx, p2_ctx, p3_ctx} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_outputs: got wr=%b dout0=%h dout1=%h dout2=%h, required 0",
                     {p0_wr_en, p1_wr_en, p2_wr_en, p3_wr_en}, p0_dout, p1_dout, p2_dout);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (got_q.size() - base !== 3) begin
            tests_failed++;
            $display("FAIL reset_no_more_writes: got %0d writes, required 3", got_q.size() - base);
        end
        base = got_q.size();
        send(word_0to6(32'h4000_0000, 4'hE));
        wait_idle();
        check_seq("post_reset", base, seq_0to6(32'h4000_0000));
    endtask

    task automatic test_back_to_back();
        int base;
        int err_base;
        int bad;
        logic [35:0]      exp_q [$];
        logic [6:0][3:0]  nibs;
        logic [6:0][31:0] data;
        logic [3:0]       marker;
        base = got_q.size();
        err_base = err_samples;
        bad = 0;
        rand_full = 1'b1;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 7; k++) begin
                nibs[k] = 4'($urandom_range(0, 15));
                data[k] = $urandom;
            end
            marker = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 13)) : 4'hE;
            if (marker == 4'hE) begin
                for (int k = 0; k < 7; k++)
                    if (nibs[k] != 4'hF) exp_q.push_back({nibs[k][1:0], nibs[k][3:2], data[k]});
            end else begin
                bad++;
            end
            send(mk_word(nibs, data, marker));
        end
        wait_idle();
        rand_full = 1'b0;
        full = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (got_q.size() - base !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d writes, required %0d", got_q.size() - base, exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            tests_run++;
            if (got_at(base + j) !== exp_q[j]) begin
                tests_failed++;
                $display("FAIL b2b_write%0d: got %h, required %h", j, got_at(base + j), exp_q[j]);
            end
        end
        tests_run++;
        if (err_samples - err_base !== bad) begin
            tests_failed++;
            $display("FAIL b2b_err: got %0d pulses, required %0d", err_samples - err_base, bad);
        end
        tests_run++;
        if (multi_wr !== 0) begin
            tests_failed++;
            $display("FAIL one_hot_wr: got %0d multi-write cycles, required 0", multi_wr);
        end
`ifdef DEMUX_STATS_EN
        tests_run++;
        if (stat_words !== 16'(exp_words) || stat_drops !== 16'(exp_drops) || stat_fill !== 16'(exp_fill)) begin
            tests_failed++;
            $display("FAIL stats: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     stat_words, stat_drops, stat_fill, exp_words, exp_drops, exp_fill);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_routing();
        test_all_filler();
        test_bad_marker();
        test_full_stall();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
